pc_dma_bus_arbiter: RTL and testbench
=====================================

Name: pc_dma_bus_arbiter

Overview:
- Decides who owns the system bus: the 8088 CPU or the 8237 DMA controller.
- Watches the CPU status lines (s_n) to find a quiescent bus, then hands the bus to DMA.
  - Drives aen_n to the 8288 bus controller and to the address buffers.
  - Drives hlda to the 8237.
  - Drives a ready hold to the CPU.
- Sits between the 8284/8288 CPU bus logic and the DMA subsystem. Replaces the discrete PC DMA-wait flip-flop chain.

Parameters:
- SYNC_CYCLES, 1: clocks spent in SYNC before the grant. Range 1..15.
- TURN_CYCLES, 1: clocks spent in TURN after release before the CPU resumes. Range 1..15.
- MAX_HOLD, 0: GRANT length in clocks that sets hold_timeout. 0 disables the check.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- s_n  in  3  CPU status S2..S0, active low. 3'b111 = passive.
- lock_n  in  1  CPU bus lock, active low.
- hrq  in  1  DMA hold request from the 8237, active high.
- aen_n  out  1  address enable, active low. 0 = DMA owns the bus; the 8288 commands are disabled.
- hlda  out  1  hold acknowledge to the 8237.
- cpu_ready  out  1  1 = CPU may proceed. 0 = CPU is held in wait states.
- dma_owner  out  1  1 while state is GRANT.
- hold_timeout  out  1  sticky flag: a GRANT reached MAX_HOLD clocks.
- grant_count  out  8  number of completed grants; wraps 255 to 0.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: aen_n=1, hlda=0, cpu_ready=1, dma_owner=0, hold_timeout=0, grant_count=0.
  - Internal: state=CPU, phase counter=0, hold counter=0, s_n_d=3'b111.
  - Reset asserted mid-GRANT drops hlda and raises aen_n immediately, with no TURN.
- s_n_d is s_n registered every clock.
- quiet = (s_n==3'b111) && (s_n_d==3'b111) && lock_n. This means at least one full passive clock after T4, with no lock.
- States:
  - CPU: aen_n=1, hlda=0, cpu_ready=1.
    - On an edge where hrq && quiet: go to SYNC, cpu_ready<=0, phase counter<=0.
    - Otherwise stay.
  - SYNC: phase counter increments each clock.
    - If s_n!=3'b111 (CPU won the race): return to CPU, cpu_ready<=1, no grant, grant_count unchanged.
    - Else if hrq==0: go to TURN (abort). aen_n stays 1.
    - Else when the phase counter reaches SYNC_CYCLES-1: go to GRANT, aen_n<=0, hlda<=1, dma_owner<=1, hold counter<=0.
    - Priority order: race > hrq drop > timeout.
  - GRANT: aen_n=0, hlda=1, cpu_ready=0. The hold counter increments (saturating at 16 bits).
    - If MAX_HOLD!=0 and the hold counter reaches MAX_HOLD-1 while hrq=1: hold_timeout<=1. There is no preemption; it is a status flag only.
    - On hrq==0: go to TURN, hlda<=0, aen_n<=1, dma_owner<=0, grant_count<=grant_count+1. All of these change on the same edge.
  - TURN: aen_n=1, hlda=0, cpu_ready=0. The phase counter counts TURN_CYCLES.
    - Then go to CPU, cpu_ready<=1.
    - hrq reasserted during TURN is ignored until back in CPU; it is re-evaluated against quiet there.
- Invariants:
  - aen_n==0 implies hlda==1 and cpu_ready==0.
  - aen_n and hlda always change on the same edge.
- Latency (SYNC_CYCLES=1, bus quiet):
  - hrq sampled high at edge k: SYNC at k, aen_n=0/hlda=1 at edge k+1.
  - Release: hrq sampled low at edge m: hlda=0/aen_n=1 at m, cpu_ready=1 at m+TURN_CYCLES.
- hold_timeout is cleared only by reset.
- s_n values other than 3'b111 during GRANT are ignored: the CPU is stalled and s_n is don't-care.

Test Plan:
- Basic grant/release (defaults):
  - Stimulus: s_n=111 for 2 clocks, hrq=1 at edge 3, then hrq=0 sampled at edge 8.
  - Response: cpu_ready=0 after edge 3; aen_n=0, hlda=1 after edge 4. After edge 8: hlda=0, aen_n=1, grant_count=1. After edge 9: cpu_ready=1.
- Busy bus:
  - Stimulus: hrq=1 held while s_n=001 for 3 clocks, then s_n=111.
  - Response: no SYNC while active. SYNC only on the 2nd passive sample; aen_n=0 one edge later.
- Lock:
  - Stimulus: lock_n=0, s_n=111, hrq=1 for 10 clocks, then lock_n=1.
  - Response: aen_n=1 and hlda=0 throughout the lock. Grant occurs 2 edges after lock_n rises.
- CPU race:
  - Stimulus: enter SYNC with SYNC_CYCLES=3, drive s_n=101 on the next edge.
  - Response: state returns to CPU, cpu_ready=1, aen_n stays 1, grant_count unchanged.
- Timeout and abort:
  - With MAX_HOLD=4, hrq held 6 clocks in GRANT: hold_timeout=1 after the 4th GRANT edge, and it stays 1 after release.
  - hrq dropped during SYNC: TURN entered, aen_n never 0.
- Reset mid-grant:
  - Stimulus: reset_n=0 asynchronously in GRANT.
  - Response: aen_n=1, hlda=0, cpu_ready=1, grant_count=0 immediately, with no clock required.

Source files
------------

// File: rtl/pc_dma_bus_arbiter.sv
// Bus ownership arbiter between the 8088 CPU and the 8237 DMA controller.
// Waits for a quiescent CPU bus, parks the CPU in wait states and hands the bus to DMA.
module pc_dma_bus_arbiter #(
    parameter int SYNC_CYCLES = 1,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] s_n,
    input  logic       lock_n,
    input  logic       hrq,
    output logic       aen_n,
    output logic       hlda,
    output logic       cpu_ready,
    output logic       dma_owner,
    output logic       hold_timeout,
    output logic [7:0] grant_count,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] ST_CPU   = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    localparam logic [3:0]  SYNC_LAST = 4'(SYNC_CYCLES - 1);
    localparam logic [3:0]  TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
    localparam bit          HOLD_CHK  = (MAX_HOLD != 0);

    logic [1:0]  state;
    logic [3:0]  phase;
    logic [15:0] hold_cnt;
    logic [2:0]  s_n_d;
    logic        timeout_q;
    logic [7:0]  grant_cnt_q;
    logic        quiet;

    // A full passive clock must follow T4 before the bus can be taken away from the CPU.
    assign quiet = (s_n == 3'b111) && (s_n_d == 3'b111) && lock_n;

    // Handshake: hrq is a level request from the 8237; hlda acknowledges it only once
    // the bus is ours, and stays high until hrq is seen low, after which the bus
    // returns to the CPU through a TURN gap. A new hrq is honoured only from CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_CPU;
            phase       <= 4'd0;
            hold_cnt    <= 16'd0;
            s_n_d       <= 3'b111;
            timeout_q   <= 1'b0;
            grant_cnt_q <= 8'd0;
        end else begin
            s_n_d <= s_n;
            case (state)
                ST_CPU: begin
                    if (hrq && quiet) begin
                        state <= ST_SYNC;
                        phase <= 4'd0;
                    end
                end
                ST_SYNC: begin
                    if (s_n != 3'b111) begin
                        state <= ST_CPU;
                    end else if (!hrq) begin
                        state <= ST_TURN;
                        phase <= 4'd0;
                    end else if (phase == SYNC_LAST) begin
                        state    <= ST_GRANT;
                        hold_cnt <= 16'd0;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (!hrq) begin
                        state       <= ST_TURN;
                        phase       <= 4'd0;
                        grant_cnt_q <= grant_cnt_q + 8'd1;
                    end else begin
                        if (hold_cnt != 16'hffff) begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                        // Status only: the DMA keeps the bus even after the limit.
                        if (HOLD_CHK && (hold_cnt == HOLD_LAST)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_TURN: begin
                    if (phase == TURN_LAST) begin
                        state <= ST_CPU;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                default: begin
                    state <= ST_CPU;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register so aen_n and hlda move together.
    assign aen_n        = (state != ST_GRANT);
    assign hlda         = (state == ST_GRANT);
    assign dma_owner    = (state == ST_GRANT);
    assign cpu_ready    = (state == ST_CPU);
    assign hold_timeout = timeout_q;
    assign grant_count  = grant_cnt_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_pc_dma_bus_arbiter.sv
// Bench for pc_dma_bus_arbiter: two parameterisations driven by the same stimulus,
// each checked every clock against a countdown-based ownership model.
module tb_pc_dma_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] s_n = 3'b111;
    logic       lock_n = 1'b1;
    logic       hrq = 1'b0;

    logic [1:0] aen_n_v, hlda_v, ready_v, owner_v, timeout_v;
    logic [7:0] gc_v [2];
    logic [1:0] st_v [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_dma_bus_arbiter #(.SYNC_CYCLES(1), .TURN_CYCLES(1), .MAX_HOLD(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .s_n(s_n), .lock_n(lock_n), .hrq(hrq),
        .aen_n(aen_n_v[0]), .hlda(hlda_v[0]), .cpu_ready(ready_v[0]),
        .dma_owner(owner_v[0]), .hold_timeout(timeout_v[0]),
        .grant_count(gc_v[0]), .state_dbg(st_v[0])
    );

    pc_dma_bus_arbiter #(.SYNC_CYCLES(3), .TURN_CYCLES(2), .MAX_HOLD(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_n(s_n), .lock_n(lock_n), .hrq(hrq),
        .aen_n(aen_n_v[1]), .hlda(hlda_v[1]), .cpu_ready(ready_v[1]),
        .dma_owner(owner_v[1]), .hold_timeout(timeout_v[1]),
        .grant_count(gc_v[1]), .state_dbg(st_v[1])
    );

    // Reference model: who owns the bus, and how many clocks remain in the current wait.
    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_OWN  = 2;
    localparam int M_TURN = 3;

    int sync_c [2] = '{1, 3};
    int turn_c [2] = '{1, 2};
    int maxh_c [2] = '{0, 4};

    int       m_mode   [2];
    int       m_left   [2];
    int       m_held   [2];
    bit       m_to     [2];
    int       m_grants [2];
    bit [2:0] m_prev_s [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]   = M_IDLE;
            m_left[i]   = 0;
            m_held[i]   = 0;
            m_to[i]     = 1'b0;
            m_grants[i] = 0;
            m_prev_s[i] = 3'b111;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            bit passive = (s_n == 3'b111);
            bit quiet   = passive && (m_prev_s[i] == 3'b111) && lock_n;
            case (m_mode[i])
                M_IDLE: if (hrq && quiet) begin
                    m_mode[i] = M_SYNC;
                    m_left[i] = sync_c[i];
                end
                M_SYNC: begin
                    if (!passive) m_mode[i] = M_IDLE;
                    else if (!hrq) begin
                        m_mode[i] = M_TURN;
                        m_left[i] = turn_c[i];
                    end else begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_mode[i] = M_OWN;
                            m_held[i] = 0;
                        end
                    end
                end
                M_OWN: begin
                    if (!hrq) begin
                        m_mode[i]   = M_TURN;
                        m_left[i]   = turn_c[i];
                        m_grants[i] = (m_grants[i] + 1) % 256;
                    end else begin
                        if (m_held[i] < 65535) m_held[i]++;
                        if (maxh_c[i] != 0 && m_held[i] == maxh_c[i]) m_to[i] = 1'b1;
                    end
                end
                default: begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_mode[i] = M_IDLE;
                end
            endcase
            m_prev_s[i] = s_n;
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string p = (i == 0) ? "a" : "b";
            check({p, ".aen_n"},        16'(aen_n_v[i]),   16'(m_mode[i] != M_OWN));
            check({p, ".hlda"},         16'(hlda_v[i]),    16'(m_mode[i] == M_OWN));
            check({p, ".cpu_ready"},    16'(ready_v[i]),   16'(m_mode[i] == M_IDLE));
            check({p, ".dma_owner"},    16'(owner_v[i]),   16'(m_mode[i] == M_OWN));
            check({p, ".hold_timeout"}, 16'(timeout_v[i]), 16'(m_to[i]));
            check({p, ".grant_count"},  16'(gc_v[i]),      16'(m_grants[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        hrq = 1'b0;
        s_n = 3'b111;
        lock_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        s_n = 3'b111;
        lock_n = 1'b1;
        hrq = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
    endtask

    logic [7:0] gc_before;

    initial begin
        model_reset();
        do_reset();

        // Basic grant/release on the default instance.
        tick();
        tick();
        hrq = 1'b1;
        tick();
        check("basic.ready_e3", 16'(ready_v[0]), 16'd0);
        check("basic.aen_e3",   16'(aen_n_v[0]), 16'd1);
        tick();
        check("basic.aen_e4",   16'(aen_n_v[0]), 16'd0);
        check("basic.hlda_e4",  16'(hlda_v[0]),  16'd1);
        repeat (3) tick();
        hrq = 1'b0;
        tick();
        check("basic.hlda_e8",  16'(hlda_v[0]),  16'd0);
        check("basic.aen_e8",   16'(aen_n_v[0]), 16'd1);
        check("basic.gc_e8",    16'(gc_v[0]),    16'd1);
        check("basic.ready_e8", 16'(ready_v[0]), 16'd0);
        tick();
        check("basic.ready_e9", 16'(ready_v[0]), 16'd1);
        drain();

        // Busy bus: no SYNC until the second passive sample.
        hrq = 1'b1;
        s_n = 3'b001;
        repeat (3) begin
            tick();
            check("busy.ready_active", 16'(ready_v[0]), 16'd1);
        end
        s_n = 3'b111;
        tick();
        check("busy.ready_pass1", 16'(ready_v[0]), 16'd1);
        tick();
        check("busy.ready_pass2", 16'(ready_v[0]), 16'd0);
        tick();
        check("busy.aen_grant", 16'(aen_n_v[0]), 16'd0);
        drain();

        // Lock holds the bus for the CPU.
        lock_n = 1'b0;
        hrq = 1'b1;
        repeat (10) begin
            tick();
            check("lock.aen", 16'(aen_n_v[0]), 16'd1);
            check("lock.hlda", 16'(hlda_v[0]), 16'd0);
        end
        lock_n = 1'b1;
        tick();
        check("lock.aen_rise1", 16'(aen_n_v[0]), 16'd1);
        tick();
        check("lock.aen_rise2", 16'(aen_n_v[0]), 16'd0);
        drain();

        // CPU wins the race against the 3-clock SYNC instance.
        gc_before = gc_v[1];
        hrq = 1'b1;
        tick();
        check("race.ready_sync", 16'(ready_v[1]), 16'd0);
        s_n = 3'b101;
        tick();
        check("race.ready_back", 16'(ready_v[1]), 16'd1);
        check("race.aen",        16'(aen_n_v[1]), 16'd1);
        check("race.gc",         16'(gc_v[1]),    16'(gc_before));
        drain();

        // Abort from SYNC: TURN without ever enabling DMA addresses.
        hrq = 1'b1;
        tick();
        hrq = 1'b0;
        tick();
        check("abort.aen_b",   16'(aen_n_v[1]), 16'd1);
        check("abort.ready_b", 16'(ready_v[1]), 16'd0);
        drain();

        // Long hold trips the sticky timeout on the MAX_HOLD=4 instance only.
        check("timeout.b_pre", 16'(timeout_v[1]), 16'd0);
        hrq = 1'b1;
        repeat (7) tick();
        check("timeout.b_edge7", 16'(timeout_v[1]), 16'd0);
        tick();
        check("timeout.b_edge8", 16'(timeout_v[1]), 16'd1);
        repeat (2) tick();
        drain();
        check("timeout.b_sticky", 16'(timeout_v[1]), 16'd1);
        check("timeout.a_off",    16'(timeout_v[0]), 16'd0);

        // Randomized traffic with a persistent request and mostly passive status.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) hrq = ~hrq;
            s_n = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            lock_n = ($urandom_range(0, 9) != 0);
            tick();
        end
        drain();

        // Asynchronous reset in the middle of a grant.
        hrq = 1'b1;
        repeat (8) tick();
        check("rst.in_grant", 16'(hlda_v[0]), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst.aen_n",     16'(aen_n_v[i]),   16'd1);
            check("rst.hlda",      16'(hlda_v[i]),    16'd0);
            check("rst.cpu_ready", 16'(ready_v[i]),   16'd1);
            check("rst.gc",        16'(gc_v[i]),      16'd0);
            check("rst.timeout",   16'(timeout_v[i]), 16'd0);
        end
        do_reset();
        hrq = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
